command_queue: RTL and testbench

//  Buffers 12-bit ALU commands {op[11:9], addr1[8:6], addr2[5:3], addr3[2:0]} from the host side.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/command_queue_if.sv | 22 ++
 rtl/command_queue.sv | 110 +++++++++++
 tb/tb_command_queue.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU command definitions: command width, opcode encoding, the packed
// command layout, and the opcode legality test used by the command queue.
package alu_pkg;

  localparam int CMD_W = 12;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_NOT = 3'b100,
    OP_NOP = 3'b111
  } alu_op_e;

  typedef struct packed {
    alu_op_e    op;
    logic [2:0] a1;
    logic [2:0] a2;
    logic [2:0] dst;
  } alu_cmd_t;

  // Opcodes 3'b101..3'b111 carry no ALU operation.
  function automatic logic is_valid_op(input logic [2:0] op);
    return op <= 3'(OP_NOT);
  endfunction

endpackage

// File: rtl/command_queue_if.sv
// Host-to-queue and queue-to-controller valid/ready handshakes carrying ALU commands.
// The queue takes the slave side; the host/controller environment takes the master side.
interface command_queue_if;

  logic                      in_valid;
  logic                      in_ready;
  logic [alu_pkg::CMD_W-1:0] in_cmd;
  logic                      out_valid;
  logic                      out_ready;
  logic [alu_pkg::CMD_W-1:0] out_cmd;

  modport master (
    output in_valid, in_cmd, out_ready,
    input  in_ready, out_valid, out_cmd
  );

  modport slave (
    input  in_valid, in_cmd, out_ready,
    output in_ready, out_valid, out_cmd
  );

endinterface

// File: rtl/command_queue.sv
// First-word-fall-through command FIFO between the host and the ALU controller.
// Define CMD_QUEUE_DROP_NOP_EN to discard non-ALU opcodes at entry and count them on drop_cnt.
module command_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  command_queue_if.slave               bus,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
`ifdef CMD_QUEUE_DROP_NOP_EN
  ,
  output logic [7:0]                   drop_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push, pop, keep, store, mem_we;

`ifdef CMD_QUEUE_DROP_NOP_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;
  assign keep     = is_valid_op(bus.in_cmd[CMD_W-1 -: 3]);
  assign drop_cnt = drop_cnt_q;
`else
  assign keep = 1'b1;
`endif

  // in_ready comes only from the registered full flag, never from out_ready.
  assign push  = bus.in_valid & ~full_q;
  assign pop   = bus.out_ready & ~empty_q;
  assign store = push & keep;

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_we   = 1'b0;
`ifdef CMD_QUEUE_DROP_NOP_EN
    drop_cnt_d = drop_cnt_q;
`endif
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      mem_we = store & ~rst;
      if (store) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({store, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
`ifdef CMD_QUEUE_DROP_NOP_EN
      if (push && !keep && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
`endif
    end
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
`ifdef CMD_QUEUE_DROP_NOP_EN
      drop_cnt_q <= '0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
`ifdef CMD_QUEUE_DROP_NOP_EN
      drop_cnt_q <= drop_cnt_d;
`endif
    end
  end

  // NOTE: storage is deliberately not reset; out_cmd is masked by empty so stale words never leak.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= bus.in_cmd;
  end

  assign bus.in_ready  = ~full_q;
  assign bus.out_valid = ~empty_q;
  assign bus.out_cmd   = empty_q ? '0 : mem_q[rd_ptr_q];
  assign count         = count_q;
  assign full          = full_q;
  assign empty         = empty_q;

endmodule

// File: tb/tb_command_queue.sv
// Self-checking bench for command_queue: directed scenarios then random traffic,
// all compared against a queue-based model of the FIFO behaviour.
module tb_command_queue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [2:0] count;
  logic       full;
  logic       empty;
`ifdef CMD_QUEUE_DROP_NOP_EN
  logic [7:0] drop_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [11:0] mq[$];
  int          mdrop = 0;

  command_queue_if bus ();

  command_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .bus      (bus),
    .count    (count),
    .full     (full),
    .empty    (empty)
`ifdef CMD_QUEUE_DROP_NOP_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_keeps(input logic [11:0] c);
`ifdef CMD_QUEUE_DROP_NOP_EN
    return c[11:9] < 3'd5;
`else
    return 1'b1;
`endif
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".count"},     32'(count),         32'(mq.size()));
    check({tag, ".empty"},     32'(empty),         32'(mq.size() == 0));
    check({tag, ".full"},      32'(full),          32'(mq.size() == DEPTH));
    check({tag, ".in_ready"},  32'(bus.in_ready),  32'(mq.size() < DEPTH));
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(mq.size() > 0));
    check({tag, ".out_cmd"},   32'(bus.out_cmd),   (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
`ifdef CMD_QUEUE_DROP_NOP_EN
    check({tag, ".drop_cnt"},  32'(drop_cnt),      32'(mdrop));
`endif
  endtask

  // One clock: drive inputs, apply the spec rules to the model, then compare.
  task automatic cycle(input string tag, input logic r, input logic fl, input logic iv,
                       input logic [11:0] c, input logic ordy);
    bit do_push, do_pop;
    rst           = r;
    flush         = fl;
    bus.in_valid  = iv;
    bus.in_cmd    = c;
    bus.out_ready = ordy;
    do_push = iv && (mq.size() < DEPTH);
    do_pop  = ordy && (mq.size() > 0);
    @(posedge clk);
    #1;
    if (r) begin
      mq.delete();
      mdrop = 0;
    end else if (fl) begin
      mq.delete();
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        if (model_keeps(c)) mq.push_back(c);
        else if (mdrop < 255) mdrop++;
      end
    end
    check_all(tag);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i <= DEPTH && mq.size() > 0; i++) cycle(tag, 0, 0, 0, 12'h000, 1);
  endtask

  initial begin
    logic [11:0] c;
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_cmd = '0; bus.out_ready = 1'b0;

    // Reset then idle
    cycle("rst0", 1, 0, 0, 12'h000, 0);
    cycle("rst1", 1, 0, 0, 12'h000, 0);
    cycle("idle", 0, 0, 0, 12'h000, 1);
    check("reset.empty_const", 32'(empty), 32'h1);
    check("reset.out_cmd_const", 32'(bus.out_cmd), 32'h0);

    // Single push, 1-cycle latency
    cycle("push1", 0, 0, 1, 12'h0C5, 0);
    check("push1.out_cmd_const", 32'(bus.out_cmd), 32'h0C5);
    check("push1.count_const", 32'(count), 32'h1);

    // Fill, hold 5th, pop opens in_ready next cycle, wrap
    cycle("fill2", 0, 0, 1, 12'h05A, 0);
    cycle("fill3", 0, 0, 1, 12'h0BC, 0);
    cycle("fill4", 0, 0, 1, 12'h123, 0);
    check("fill.full_const", 32'(full), 32'h1);
    cycle("hold5", 0, 0, 1, 12'h1FF, 0);
    cycle("pop_full", 0, 0, 1, 12'h1FF, 1);
    check("pop_full.in_ready_const", 32'(bus.in_ready), 32'h1);
    check("pop_full.out_cmd_const", 32'(bus.out_cmd), 32'h05A);
    cycle("wrap_push", 0, 0, 1, 12'h1FF, 0);
    drain("drain_wrap");

    // Steady concurrent push/pop at count 2
    cycle("pp_a", 0, 0, 1, 12'h011, 0);
    cycle("pp_b", 0, 0, 1, 12'h022, 0);
    for (int i = 0; i < 10; i++) begin
      cycle("pp", 0, 0, 1, 12'($urandom_range(0, 12'h9FF)), 1);
      check("pp.count_const", 32'(count), 32'h2);
    end
    drain("drain_pp");

    // Flush with a concurrent push
    cycle("fl_a", 0, 0, 1, 12'h031, 0);
    cycle("fl_b", 0, 0, 1, 12'h032, 0);
    cycle("fl_c", 0, 0, 1, 12'h033, 0);
    cycle("flush", 0, 1, 1, 12'h0AA, 1);
    check("flush.empty_const", 32'(empty), 32'h1);
    cycle("post_flush", 0, 0, 0, 12'h000, 1);

    // Non-ALU opcode handling
    cycle("nop_push", 0, 0, 1, 12'hE00, 0);
    cycle("sub_push", 0, 0, 1, 12'h200, 0);
`ifdef CMD_QUEUE_DROP_NOP_EN
    check("drop.head_const", 32'(bus.out_cmd), 32'h200);
    check("drop.cnt_const", 32'(drop_cnt), 32'h1);
`else
    check("nodrop.head_const", 32'(bus.out_cmd), 32'hE00);
    check("nodrop.count_const", 32'(count), 32'h2);
`endif
    drain("drain_nop");

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 600; i++) begin
      c = 12'($urandom);
      cycle("rand", ($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
            1'($urandom), c, ($urandom_range(0, 2) != 0));
    end
    drain("drain_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit expired");
  end

endmodule
